// File: rtl/ss_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ss_bus_arbiter
//
// Arbitrates two requesters (0: save-state controller, 1: debug/cheat engine)
// onto the shared save-state register bus. Before any bus access the core is
// asked to halt (ss_halt). The access is granted only once the core reports
// that the bus is safe (ss_ready). Back-to-back requests that arrive while the
// core is still halted are served without releasing the halt.
//
// Parameters
//   READ_LATENCY  cycles from bus_addr stable to bus_out valid (>= 1)
//   HALT_TIMEOUT  maximum HALT_WAIT cycles when SS_ARB_TIMEOUT_EN is defined
//
// Optional feature (compile-time macro SS_ARB_TIMEOUT_EN)
//   Defined   : HALT_WAIT gives up after HALT_TIMEOUT cycles. The round-robin
//               winner then receives ack, done and err in the same cycle, and
//               no bus access is made.
//   Undefined : HALT_WAIT waits indefinitely and err is constant 0.
//
// Ports
//   clk_sys                    in   system clock, rising edge
//   reset_n                    in   synchronous active-low reset
//   reqN_valid/we/addr/wdata   in   request from requester N (N = 0, 1)
//   reqN_ack                   out  one-cycle pulse, request accepted
//   reqN_done                  out  one-cycle pulse, access complete
//   rdata[31:0]                out  last read data, held until the next read
//   bus_addr[7:0]              out  shared bus address (holds last value)
//   bus_in[31:0]               out  shared bus write data (holds last write)
//   bus_wren                   out  shared bus write strobe
//   bus_out[31:0]              in   shared bus read data
//   ss_halt                    out  core halt request
//   ss_ready                   in   core halted, bus safe
//   err                        out  pulses together with done on an abort
// ---------------------------------------------------------------------------
module ss_bus_arbiter #(
  parameter int READ_LATENCY = 10,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [7:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [7:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req0_ack,
  output logic        req1_ack,
  output logic        req0_done,
  output logic        req1_done,
  output logic [31:0] rdata,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_in,
  output logic        bus_wren,
  input  logic [31:0] bus_out,
  output logic        ss_halt,
  input  logic        ss_ready,
  output logic        err
);

  localparam int CNT_MAX = (READ_LATENCY > HALT_TIMEOUT) ? READ_LATENCY : HALT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_GRANT     = 3'd2,
    S_WRITE     = 3'd3,
    S_READ_WAIT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;    // requester served most recently
  logic               r_owner;   // requester owning the current access

  logic               w_any;
  logic               w_win;
  logic               w_win_we;
  logic               w_access;
  logic               w_rd_last;
  logic               w_tmo;

  assign w_any = req0_valid | req1_valid;

  // Round-robin: a lone requester wins; on contention the one not served
  // last wins. r_last resets to 1 so requester 0 wins the first contention.
  assign w_win    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_win_we = w_win ? req1_we : req0_we;

  // A grant only turns into a bus access while the core is still halted.
  assign w_access  = (r_state == S_GRANT) & ss_ready & w_any;
  assign w_rd_last = (r_cnt == CNT_W'(READ_LATENCY - 1));

`ifdef SS_ARB_TIMEOUT_EN
  assign w_tmo = (r_state == S_HALT_WAIT) & ~ss_ready &
                 (r_cnt == CNT_W'(HALT_TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        if (ss_ready)   w_state_nxt = S_GRANT;
        else if (w_tmo) w_state_nxt = S_IDLE;
      end
      S_GRANT: begin
        // Core resumed before the grant: re-request the halt.
        if (!ss_ready)      w_state_nxt = S_HALT_WAIT;
        else if (!w_any)    w_state_nxt = S_IDLE;
        else if (w_win_we)  w_state_nxt = S_WRITE;
        else                w_state_nxt = S_READ_WAIT;
      end
      S_WRITE: begin
        w_state_nxt = S_DONE;
      end
      S_READ_WAIT: begin
        if (w_rd_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Burst: keep the halt when more work is pending and the core is halted.
        if (w_any && ss_ready) w_state_nxt = S_GRANT;
        else                   w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ack  = 1'b0;
    req1_ack  = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    err       = 1'b0;
    ss_halt   = (r_state != S_IDLE);
    bus_wren  = (r_state == S_WRITE);
    if (w_access || (w_tmo && w_any)) begin
      req0_ack = ~w_win;
      req1_ack = w_win;
    end
    if (r_state == S_DONE) begin
      req0_done = ~r_owner;
      req1_done = r_owner;
    end else if (w_tmo && w_any) begin
      req0_done = ~w_win;
      req1_done = w_win;
      err       = 1'b1;
    end
  end

  // Counter, ownership and bus datapath
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      bus_addr <= '0;
      bus_in   <= '0;
      rdata    <= '0;
    end else begin
      // Counter restarts on every state change so each wait starts at 0.
      if (r_state != w_state_nxt) begin
        r_cnt <= '0;
      end else if (r_state == S_READ_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
`ifdef SS_ARB_TIMEOUT_EN
      end else if (r_state == S_HALT_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
`endif
      end

      if (w_access) begin
        r_owner  <= w_win;
        bus_addr <= w_win ? req1_addr : req0_addr;
        if (w_win_we) bus_in <= w_win ? req1_wdata : req0_wdata;
      end

      if (r_state == S_DONE) begin
        r_last <= r_owner;
      end else if (w_tmo && w_any) begin
        r_last <= w_win;
      end

      if ((r_state == S_READ_WAIT) && w_rd_last) begin
        rdata <= bus_out;
      end
    end
  end

endmodule

// File: doc/ss_bus_arbiter.md
SS_BUS_ARBITER -- requirements
Module: ss_bus_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 10: cycles from bus_addr stable to bus_out valid.
REQ-002 Parameter HALT_TIMEOUT, default 255: maximum cycles to wait for ss_ready (used only under REQ-031).
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1 each  access request from requester 0 (save-state controller) / requester 1 (debug/cheat engine).
REQ-006 req0_we / req1_we  in  1 each  1 = write, 0 = read; valid while reqN_valid is high.
REQ-007 req0_addr / req1_addr  in  8 each  register-bus address.
REQ-008 req0_wdata / req1_wdata  in  32 each  write data.
REQ-009 req0_ack / req1_ack  out  1 each  one-cycle pulse; request accepted.
REQ-010 req0_done / req1_done  out  1 each  one-cycle pulse; access complete and rdata valid for reads.
REQ-011 rdata  out  32  captured bus_out, held until the next read completes.
REQ-012 bus_addr  out  8, bus_in  out  32, bus_wren  out  1  shared save-state register bus.
REQ-013 bus_out  in  32  shared bus read data.
REQ-014 ss_halt  out  1  core halt request; ss_ready  in  1  core halted and bus safe.
REQ-015 err  out  1  one-cycle pulse together with done when an access is aborted.

Function
REQ-016 States: IDLE, HALT_WAIT, GRANT, WRITE, READ_WAIT, DONE.
REQ-017 IDLE: if either reqN_valid is high, assert ss_halt and go to HALT_WAIT; otherwise ss_halt is deasserted.
REQ-018 HALT_WAIT: stay until ss_ready is high, then go to GRANT; ss_halt is held high.
REQ-019 GRANT: choose the owner round-robin. A requester that is the only one valid wins. If both are valid, the requester not served last wins. After reset, requester 0 is the last-served winner candidate.
REQ-020 GRANT: pulse the winner's ack, latch its addr, we and wdata, drive bus_addr, then go to WRITE (we=1) or READ_WAIT (we=0).
REQ-021 WRITE: bus_wren is high for exactly one cycle with the latched bus_in and bus_addr, then go to DONE.
REQ-022 READ_WAIT: bus_wren stays 0. A counter counts READ_LATENCY cycles. On the final cycle, rdata <= bus_out, then go to DONE.
REQ-023 DONE: pulse the owner's done and record it as last served. If any reqN_valid is high and ss_ready is still high, go to GRANT with ss_halt held (back-to-back burst, no re-halt). Otherwise deassert ss_halt and go to IDLE.
REQ-024 If ss_ready drops while in GRANT, skip the access: no ack, and return to HALT_WAIT.
REQ-025 Requesters hold addr/we/wdata stable from valid until ack. A requester that drops valid before ack is simply not served.
REQ-026 bus_addr holds its last value outside accesses. bus_in holds the last write data.
REQ-027 Counter width is clog2(max(READ_LATENCY, HALT_TIMEOUT)+1); no wrap occurs within one access.
REQ-028 At most one ack and at most one done are asserted in any cycle.

Reset
REQ-029 While reset_n is low at a clk_sys edge: state=IDLE; ss_halt, bus_wren, all ack, done and err = 0; bus_addr=0; bus_in=0; rdata=0; last-served=1; counters=0.
REQ-030 Reset mid-access aborts immediately: no done is pulsed, bus_wren=0 on the next cycle, ss_halt released.

Configuration
REQ-031 With SS_ARB_TIMEOUT_EN defined, a HALT_WAIT counter runs. If ss_ready is still low after HALT_TIMEOUT cycles, do the following in one cycle: grant the round-robin winner, pulse its ack, done and err together, deassert ss_halt, return to IDLE, and perform no bus access. Without SS_ARB_TIMEOUT_EN, HALT_WAIT waits indefinitely and err is tied to 0.

Verification
REQ-032 Single write: req0 addr=0x12 wdata=0xDEADBEEF, ss_ready rising 3 cycles after ss_halt -> exactly one cycle of bus_wren with bus_addr=0x12 and bus_in=0xDEADBEEF, req0_done on the next cycle, then ss_halt low.
REQ-033 Read latency: req1 read addr=0x40, bus_out=0xCAFE0001 -> req1_done exactly READ_LATENCY+1 cycles after req1_ack, rdata=0xCAFE0001.
REQ-034 Contention: both valid continuously for 4 accesses after reset -> grant order 0,1,0,1, ss_halt high throughout, no re-entry to HALT_WAIT.
REQ-035 ss_ready low during GRANT -> no ack, return to HALT_WAIT, access completes after ss_ready returns.
REQ-036 Timeout (SS_ARB_TIMEOUT_EN defined, HALT_TIMEOUT=255): ss_ready held at 0 -> ack, done and err pulsed together at cycle 255, bus_wren never asserted; without the macro, the block is still in HALT_WAIT at cycle 1000.
REQ-037 Reset asserted during READ_WAIT -> no done pulsed, all outputs at REQ-029 values one edge later.
